// File: rtl/scan_pkg.sv
// Shared types and constants for the matrix scan sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package scan_pkg;

  // Width of one driver-chip word shifted per chip per row.
  localparam int WORD_BITS = 14;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    BLANK,
    LATCH,
    UNBLANK
  } state_t;

  // $clog2 that never returns zero, so single-entry dimensions still get a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter timing the blank/latch/unblank intervals.
// Latency: done is combinational on the count; a load of N gives N+1 cycles until done.
// Backpressure: none; load has priority over counting, count holds at zero.
module scan_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Row-scan sequencer: fetches NCHIPS words per row, shifts them out, then blanks/latches/unblanks; SCAN_CONTINUOUS_EN selects free-running frames.
// Latency: FETCH one cycle after start; rddata captured the cycle after rdaddr; frame_done one cycle after the final UNBLANK cycle.
// Backpressure: SHIFT waits indefinitely for wrpulse; start is ignored while busy.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int NROWS        = 16,
  parameter int NCHIPS       = 4,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic [clog2_min1(NROWS*NCHIPS)-1:0]  rdaddr,
  input  logic [WORD_BITS-1:0]                 rddata,
  output logic [WORD_BITS-1:0]                 chpdata,
  output logic                                 init,
  output logic                                 cs,
  output logic                                 wrreset,
  input  logic                                 wrpulse,
  output logic                                 latch,
  output logic                                 oe,
  output logic [clog2_min1(NROWS)-1:0]         row,
  output logic                                 busy,
  output logic                                 frame_done
);

  localparam int AW   = clog2_min1(NROWS*NCHIPS);
  localparam int RW   = clog2_min1(NROWS);
  localparam int CW   = clog2_min1(NCHIPS);
  localparam int BW   = $clog2(WORD_BITS + 1);
  // Half of the blanking window; at least one cycle so the timer load never underflows.
  localparam int HALF = (BLANK_CYCLES / 2 > 0) ? BLANK_CYCLES / 2 : 1;
  localparam int TW   = clog2_min1(HALF + 1);

  localparam logic [RW-1:0] LAST_ROW   = RW'(NROWS - 1);
  localparam logic [CW-1:0] LAST_CHIP  = CW'(NCHIPS - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WORD_BITS - 1);
  localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF - 1);
  localparam logic [TW-1:0] LATCH_LOAD = TW'(1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   chip;
  logic [BW-1:0]   bitcnt;
  logic            lit;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_done;
  logic            word_end;
  logic            row_end;
  logic            frame_end;

  // The last bit of a word is the one whose pulse brings the count to WORD_BITS;
  // that same pulse is counted and ends SHIFT, so a coincident pulse is never lost or doubled.
  assign word_end  = (state == SHIFT) && wrpulse && (bitcnt == LAST_BIT);
  assign row_end   = (state == UNBLANK) && tmr_done;
  // The row register has already advanced during LATCH, so a zero here means the last row was just shown.
  assign frame_end = row_end && (row == '0);

  assign rdaddr = AW'(AW'(row) * AW'(NCHIPS) + AW'(chip));

  scan_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, interval timer control and per-state strobes.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    wrreset   = 1'b0;
    init      = 1'b0;
    cs        = 1'b0;
    latch     = 1'b0;
    oe        = lit;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        wrreset   = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        init      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        cs = 1'b1;
        if (word_end) begin
          if (chip != LAST_CHIP) begin
            state_nxt = FETCH;
          end else begin
            state_nxt = BLANK;
            tmr_load  = 1'b1;
            tmr_val   = HALF_LOAD;
          end
        end
      end
      BLANK: begin
        oe = 1'b0;
        if (tmr_done) begin
          state_nxt = LATCH;
          tmr_load  = 1'b1;
          tmr_val   = LATCH_LOAD;
        end
      end
      LATCH: begin
        oe    = 1'b0;
        latch = 1'b1;
        if (tmr_done) begin
          state_nxt = UNBLANK;
          tmr_load  = 1'b1;
          tmr_val   = HALF_LOAD;
        end
      end
      UNBLANK: begin
        oe = 1'b0;
        if (tmr_done) begin
          if (row == '0) begin
`ifdef SCAN_CONTINUOUS_EN
            state_nxt = FETCH;
`else
            state_nxt = IDLE;
`endif
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word capture and bit counting for the shift phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chpdata <= '0;
      bitcnt  <= '0;
    end else if (state == LOAD) begin
      chpdata <= rddata;
      bitcnt  <= '0;
    end else if ((state == SHIFT) && wrpulse) begin
      bitcnt <= bitcnt + 1'b1;
    end
  end

  // Row/chip position, lit flag (kept on while the next row shifts) and frame strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row        <= '0;
      chip       <= '0;
      lit        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (word_end && (chip != LAST_CHIP)) begin
        chip <= chip + 1'b1;
      end
      if ((state == LATCH) && tmr_done) begin
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end
      if (row_end) begin
        chip <= '0;
        lit  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter NROWS, default 16: number of matrix scan rows per frame.
REQ-002 Parameter NCHIPS, default 4: number of 14-bit driver words shifted per row.
REQ-003 Parameter BLANK_CYCLES, default 8: clk cycles the output enable stays off around a latch.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level request to begin one frame scan.
REQ-007 rdaddr  out  $clog2(NROWS*NCHIPS)  frame-buffer read address, row*NCHIPS+chip.
REQ-008 rddata  in  14  frame-buffer word, valid one cycle after rdaddr.
REQ-009 chpdata  out  14  registered word handed to the display write engine.
REQ-010 init  out  1  one-cycle parallel-load strobe to the write engine.
REQ-011 cs  out  1  shift enable to the write engine, high while a word is shifting.
REQ-012 wrreset  out  1  clears the write engine's bit-clock counter, high for one cycle before each word.
REQ-013 wrpulse  in  1  one-cycle pulse from the write engine per shifted bit.
REQ-014 latch  out  1  row latch strobe to the driver chips.
REQ-015 oe  out  1  row output enable, active-high.
REQ-016 row  out  $clog2(NROWS)  currently displayed row address.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 frame_done  out  1  one-cycle pulse after the last row of a frame is latched.

Function
REQ-019 The FSM states SHALL be IDLE, FETCH, LOAD, SHIFT, BLANK, LATCH, UNBLANK.
REQ-020 IDLE->FETCH when start=1; start while busy=1 is ignored.
REQ-021 FETCH (1 cycle): drive rdaddr for the current row and chip; wrreset=1.
REQ-022 LOAD (1 cycle): chpdata<=rddata, init=1, bit counter<=0; next state SHIFT.
REQ-023 SHIFT: cs=1; each wrpulse increments the bit counter; on the 14th wrpulse, cs drops in the following cycle.
REQ-024 After SHIFT, if chip<NCHIPS-1, increment chip and go to FETCH; otherwise go to BLANK.
REQ-025 BLANK: oe=0 for BLANK_CYCLES/2 cycles, then LATCH.
REQ-026 LATCH (2 cycles): latch=1, oe=0; on the second cycle, row<=next row.
REQ-027 UNBLANK: oe=0 for BLANK_CYCLES/2 cycles, then oe=1 and chip<=0.
REQ-028 Leaving UNBLANK with the old row < NROWS-1 goes to FETCH.
REQ-029 Leaving UNBLANK with the old row = NROWS-1: row wraps to 0, frame_done=1 for one cycle, and the next state is set by REQ-035/036.
REQ-030 oe SHALL stay 1 during FETCH/LOAD/SHIFT of rows after the first, so the previous row stays lit while the next row shifts.
REQ-031 A wrpulse outside SHIFT SHALL be ignored.
REQ-032 If wrpulse and the SHIFT exit coincide, only one count SHALL be taken and no bit is lost.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE, row=0, chip=0, bit counter=0, and all outputs to 0 (chpdata=0, oe=0, latch=0, cs=0, init=0, wrreset=0, busy=0, frame_done=0), including when reset arrives mid-shift.
REQ-034 After reset deasserts, no output SHALL change until start=1.

Configuration
REQ-035 With SCAN_CONTINUOUS_EN defined, after frame_done the FSM SHALL go directly to FETCH of row 0 regardless of start, scanning forever.
REQ-036 Without SCAN_CONTINUOUS_EN, after frame_done the FSM SHALL go to IDLE with oe held at 1 for row NROWS-1 until the next start.

Structure
REQ-037 A shared package scan_pkg SHALL hold the state enum typedef and WORD_BITS=14.
REQ-038 One sub-module, scan_timer, a loadable down-counter, SHALL time the BLANK, LATCH and UNBLANK intervals.

Verification
REQ-039 NROWS=2, NCHIPS=2, start pulse, behavioural write engine returning wrpulse every 4 cycles -> exactly 4 init pulses and 56 wrpulses are consumed, and rdaddr sequence is 0,1,2,3.
REQ-040 Same run -> each latch pulse is 2 cycles wide, oe=0 for BLANK_CYCLES+2 cycles around it, and frame_done pulses once.
REQ-041 Assert reset during the 7th wrpulse of word 1 -> all outputs are 0 in the same cycle and the FSM is in IDLE.
REQ-042 Pulse start while busy=1 -> no effect on the sequence.
REQ-043 Pulse wrpulse while in IDLE -> counter stays at 0.
REQ-044 SCAN_CONTINUOUS_EN defined, start pulsed once -> rdaddr returns to 0 after frame_done and a second frame_done follows; without the macro -> busy=0 after the first frame.
